// File: rtl/dec_scanner_if.sv
// dec_scanner_if: control inputs and decoded outputs of dec_scanner bundled into one interface
interface dec_scanner_if #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
);
  logic                  en;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [DWELL_W-1:0]    dwell;
  logic [2**SEL_W-1:0]   onehot_o;
  logic [SEL_W-1:0]      idx_o;
  logic                  wrap_o;
  logic                  busy;
  modport master (output en, mode, sel, dwell, input onehot_o, idx_o, wrap_o, busy);
  modport slave  (input en, mode, sel, dwell, output onehot_o, idx_o, wrap_o, busy);
endinterface

// File: rtl/dec_scanner.sv
// dec_scanner: registered one-hot decoder with direct select and dwell-timed auto-scan (clk, rst, bus: en/mode/sel/dwell in; onehot_o/idx_o/wrap_o/busy out)
module dec_scanner #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  dec_scanner_if.slave  bus
);
  localparam int N = 2**SEL_W;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t             state_q;
  logic [N-1:0]       onehot_q;
  logic [SEL_W-1:0]   idx_q;
  logic               wrap_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [SEL_W-1:0]   idx_d;
  assign idx_d = idx_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      idx_q    <= '0;
      wrap_q   <= 1'b0;
      dwell_q  <= '0;
      cnt_q    <= '0;
    end else if (!bus.en) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      idx_q    <= '0;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (!bus.mode) begin
      state_q  <= DIRECT;
      onehot_q <= N'(1) << bus.sel;
      idx_q    <= bus.sel;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q != SCAN) begin
      // scan entry: start index and dwell are sampled only here
      state_q  <= SCAN;
      onehot_q <= N'(1) << bus.sel;
      idx_q    <= bus.sel;
      dwell_q  <= bus.dwell;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (cnt_q == dwell_q) begin
      onehot_q <= N'(1) << idx_d;
      idx_q    <= idx_d;
      wrap_q   <= &idx_q;
      cnt_q    <= '0;
    end else begin
      wrap_q   <= 1'b0;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
  assign bus.onehot_o = onehot_q;
  assign bus.idx_o    = idx_q;
  assign bus.wrap_o   = wrap_q;
  assign bus.busy     = (state_q == SCAN);
endmodule

// File: tb/tb_dec_scanner.sv
// tb_dec_scanner: directed checks of decode, scan timing, wrap, mode switching, disable and reset
module tb_dec_scanner;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  bit inv_on = 1'b0;
  dec_scanner_if #(.SEL_W(4), .DWELL_W(8)) bus ();
  dec_scanner #(.SEL_W(4), .DWELL_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [15:0] oh, input logic [3:0] idx, input logic w, input logic b);
    chk({tag, ".onehot"}, 32'(bus.onehot_o), 32'(oh));
    chk({tag, ".idx"}, 32'(bus.idx_o), 32'(idx));
    chk({tag, ".wrap"}, 32'(bus.wrap_o), 32'(w));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
  endtask
  always @(negedge clk) begin
    if (inv_on) begin
      checks++;
      assert ($countones(bus.onehot_o) <= 1 &&
              (bus.onehot_o == 16'h0 || bus.onehot_o == (16'h1 << bus.idx_o)) &&
              (!bus.busy || $countones(bus.onehot_o) == 1) &&
              (bus.onehot_o != 16'h0 || bus.idx_o == 4'd0)) else begin
        errors++;
        $error("FAIL invariant: onehot %0h idx %0d busy %0b", bus.onehot_o, bus.idx_o, bus.busy);
      end
    end
  end
  initial begin
    logic [3:0] scan_idx [13];
    logic       scan_wrap [13];
    scan_idx  = '{4'd14, 4'd14, 4'd14, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    scan_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1; bus.en = 1'b0; bus.mode = 1'b0; bus.sel = 4'd0; bus.dwell = 8'd0;
    tick; tick;
    inv_on = 1'b1;
    chk_out("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    bus.en = 1'b1; bus.mode = 1'b1; bus.sel = 4'd9; bus.dwell = 8'd3;
    tick;
    chk_out("reset_over_en", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst = 1'b0; bus.mode = 1'b0;
    for (int s = 0; s < 16; s++) begin
      bus.sel = 4'(s);
      tick;
      chk_out("direct", 16'h1 << s, 4'(s), 1'b0, 1'b0);
    end
    bus.sel = 4'd5;
    tick;
    chk_out("disable_pre", 16'h0020, 4'd5, 1'b0, 1'b0);
    bus.en = 1'b0;
    tick;
    chk_out("disable", 16'h0000, 4'd0, 1'b0, 1'b0);
    bus.en = 1'b1; bus.mode = 1'b1; bus.sel = 4'd14; bus.dwell = 8'd2;
    tick;
    chk_out("scan0", 16'h4000, 4'd14, 1'b0, 1'b1);
    bus.sel = 4'd3; bus.dwell = 8'd0;
    for (int i = 1; i < 13; i++) begin
      tick;
      chk_out("scan", 16'h1 << scan_idx[i], scan_idx[i], scan_wrap[i], 1'b1);
    end
    bus.en = 1'b0;
    tick;
    chk_out("idle2", 16'h0000, 4'd0, 1'b0, 1'b0);
    bus.en = 1'b1; bus.sel = 4'd0; bus.dwell = 8'd0;
    tick;
    chk_out("fast_entry0", 16'h0001, 4'd0, 1'b0, 1'b1);
    tick;
    chk_out("fast1", 16'h0002, 4'd1, 1'b0, 1'b1);
    tick;
    chk_out("fast2", 16'h0004, 4'd2, 1'b0, 1'b1);
    tick;
    chk_out("fast3", 16'h0008, 4'd3, 1'b0, 1'b1);
    bus.mode = 1'b0; bus.sel = 4'd9;
    tick;
    chk_out("scan_to_direct", 16'h0200, 4'd9, 1'b0, 1'b0);
    bus.mode = 1'b1; bus.sel = 4'd4; bus.dwell = 8'd1;
    tick;
    chk_out("direct_to_scan", 16'h0010, 4'd4, 1'b0, 1'b1);
    tick;
    chk_out("dwell1_hold", 16'h0010, 4'd4, 1'b0, 1'b1);
    tick;
    chk_out("dwell1_adv", 16'h0020, 4'd5, 1'b0, 1'b1);
    bus.en = 1'b0;
    tick;
    bus.en = 1'b1; bus.sel = 4'd6; bus.dwell = 8'd0;
    tick;
    chk_out("rscan6", 16'h0040, 4'd6, 1'b0, 1'b1);
    tick;
    chk_out("rscan7", 16'h0080, 4'd7, 1'b0, 1'b1);
    rst = 1'b1;
    tick;
    chk_out("mid_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst = 1'b0; bus.sel = 4'd2;
    tick;
    chk_out("restart", 16'h0004, 4'd2, 1'b0, 1'b1);
    bus.en = 1'b0;
    tick;
    bus.en = 1'b1; bus.sel = 4'd15;
    tick;
    chk_out("wrap_entry15", 16'h8000, 4'd15, 1'b0, 1'b1);
    tick;
    chk_out("wrap_fast", 16'h0001, 4'd0, 1'b1, 1'b1);
    tick;
    chk_out("wrap_after", 16'h0002, 4'd1, 1'b0, 1'b1);
    inv_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dec_scanner.md
DEC_SCANNER -- requirements
Module: dec_scanner

Interface
REQ-001 Parameter SEL_W, default 4: select width; one-hot output width is 2**SEL_W.
REQ-002 Parameter DWELL_W, default 8: width of the scan dwell count.
REQ-003 Port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port en, input, 1: enable; 0 forces outputs to zero.
REQ-006 Port mode, input, 1: 0 = direct decode, 1 = auto-scan.
REQ-007 Port sel, input, SEL_W: decode select in direct mode and scan start index.
REQ-008 Port dwell, input, DWELL_W: cycles-per-index minus one in scan mode.
REQ-009 Port onehot_o, output, 2**SEL_W: registered one-hot decode; all zero when inactive.
REQ-010 Port idx_o, output, SEL_W: registered index currently asserted.
REQ-011 Port wrap_o, output, 1: one-cycle pulse when scan wraps from last index to 0.
REQ-012 Port busy, output, 1: high while in SCAN state.

Function
REQ-013 The block SHALL implement three states, IDLE, DIRECT and SCAN, encoded in a registered state variable.
REQ-014 In any state, en=0 SHALL move the block to IDLE on the next edge; in IDLE, onehot_o=0, idx_o=0, wrap_o=0, busy=0.
REQ-015 From IDLE, en=1 with mode=0 SHALL enter DIRECT, and en=1 with mode=1 SHALL enter SCAN, on the next edge.
REQ-016 In DIRECT, onehot_o SHALL equal 1<<sel and idx_o SHALL equal sel, with a latency of one clock from sel to output.
REQ-017 On SCAN entry, the block SHALL load idx_o from sel, capture dwell into an internal dwell register, clear the dwell counter, and assert onehot_o=1<<sel in the same edge.
REQ-018 In SCAN, each index SHALL remain asserted for exactly (captured dwell + 1) cycles; dwell=0 advances every cycle.
REQ-019 Changes on sel and dwell while in SCAN SHALL be ignored until the next SCAN entry.
REQ-020 Index advance SHALL increment idx_o by 1 modulo 2**SEL_W.
REQ-021 wrap_o SHALL be 1 for exactly the one cycle in which idx_o first shows 0 after (2**SEL_W)-1; it SHALL NOT pulse on SCAN entry with sel=0.
REQ-022 Mode 1->0 while en=1 SHALL move SCAN to DIRECT on the next edge, with the output then decoding sel and the dwell counter cleared.
REQ-023 Mode 0->1 while en=1 SHALL move DIRECT to SCAN on the next edge, performing the REQ-017 entry load.
REQ-024 Priority SHALL be rst > en=0 > mode.
REQ-025 onehot_o SHALL always have at most one bit set, and exactly one bit in DIRECT and SCAN.
REQ-026 busy SHALL be 1 exactly when the state is SCAN.

Reset
REQ-027 With rst=1 at an edge, the next state SHALL be IDLE with onehot_o=0, idx_o=0, wrap_o=0, busy=0, and the dwell counter and dwell register zeroed, regardless of en, mode, sel or dwell.
REQ-028 Reset asserted mid-scan SHALL abort the scan; after rst falls with en=1 and mode=1, scanning SHALL restart from the current sel.
REQ-029 Reset SHALL never act asynchronously; outputs SHALL change only at clk edges.

Verification
REQ-030 Direct sweep with SEL_W=4, en=1, mode=0, sel 0..15 one per cycle: onehot_o = 0x0001..0x8000, each one cycle after its sel, with busy=0.
REQ-031 Disable test, direct mode with sel=5, then en=0: onehot_o=0x0020, then 0x0000 on the next edge, with idx_o=0.
REQ-032 Scan test with sel=14, dwell=2, mode=1: idx_o sequence 14,14,14,15,15,15,0,0,0,1..., with wrap_o high only on the first cycle of idx 0 and busy=1 throughout.
REQ-033 Mid-scan change with dwell=0, sel=0: idx_o increments every cycle; mode->0 with sel=9 at idx 3 gives onehot_o=0x0200 on the next edge and busy=0.
REQ-034 Reset mid-scan: rst=1 for one cycle at idx 7 zeroes all outputs; with rst=0, en=1, mode=1 and sel=2, idx_o restarts at 2 on the following edge.
REQ-035 Bench SHALL check the one-hot invariant of REQ-025 and REQ-026 every cycle across all scenarios.
